// File: rtl/seven_segment_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seven_segment_capture                                        |
// | Description : Receiver for a multiplexed seven-segment link. Waits for     |
// |               each anode dwell to settle and decodes it to BCD, then       |
// |               rebuilds four-digit frames. Macro SEG_CAPTURE_DP_EN enables  |
// |               decimal-point capture.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seven_segment_capture #(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  seg,
   input  logic [3:0]  an,
   output logic [3:0]  digit_1,
   output logic [3:0]  digit_2,
   output logic [3:0]  digit_3,
   output logic [3:0]  digit_4,
   output logic [13:0] value,
   output logic [3:0]  dp,
   output logic        frame_valid,
   output logic        frame_error,
   output logic        scan_lost
);

   localparam int c_CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam int c_TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_SETTLE    = c_CNT_W'(SETTLE_CYCLES);
   localparam logic [c_CNT_W-1:0] c_SETTLE_M1 = c_CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [c_TMO_W-1:0] c_TMO_PEN   = c_TMO_W'(TIMEOUT_CYCLES - 2);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_COLLECT = 1'b1} state_t;

   state_t             r_state;
   logic               w_dp_raw;
   logic [11:0]        w_in;
   logic [11:0]        r_in;
   logic               w_same;
   logic [c_CNT_W-1:0] r_settle;
   logic               w_valid;
   logic [1:0]         w_pos;
   logic [4:0]         w_dec;
   logic               w_cap;
   logic [3:0][3:0]    r_stage;
   logic [3:0][3:0]    w_stage_n;
   logic [3:0]         r_seen;
   logic [3:0]         w_seen_n;
   logic [3:0]         r_err;
   logic [3:0]         w_err_n;
   logic [3:0]         r_dps;
   logic [3:0]         w_dps_n;
   logic [c_TMO_W-1:0] r_tmo;
   logic               w_done;
   logic               w_timeout;
   logic [13:0]        w_value;

   // Without dp support seg[7] is held constant so it never disturbs the stability compare.
`ifdef SEG_CAPTURE_DP_EN
   assign w_dp_raw = seg[7];
`else
   logic w_unused_dp;
   assign w_unused_dp = seg[7];
   assign w_dp_raw    = 1'b1;
`endif

   assign w_in   = {w_dp_raw, seg[6:0], an};
   assign w_same = (w_in == r_in);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_in     <= 12'hFFF;
         r_settle <= '0;
      end else begin
         r_in <= w_in;
         if (!w_same)
            r_settle <= '0;
         else if (r_settle != c_SETTLE)
            r_settle <= r_settle + 1'b1;
      end
   end

   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h40:   decode = 5'd0;
         7'h79:   decode = 5'd1;
         7'h24:   decode = 5'd2;
         7'h30:   decode = 5'd3;
         7'h19:   decode = 5'd4;
         7'h12:   decode = 5'd5;
         7'h02:   decode = 5'd6;
         7'h78:   decode = 5'd7;
         7'h00:   decode = 5'd8;
         7'h10:   decode = 5'd9;
         default: decode = 5'h10;
      endcase
   endfunction

   always_comb begin
      w_valid = 1'b1;
      w_pos   = 2'd0;
      case (r_in[3:0])
         4'b1110: w_pos = 2'd0;
         4'b1101: w_pos = 2'd1;
         4'b1011: w_pos = 2'd2;
         4'b0111: w_pos = 2'd3;
         default: w_valid = 1'b0;
      endcase
   end

   assign w_dec = decode(r_in[10:4]);
   assign w_cap = w_same && (r_settle == c_SETTLE_M1) && w_valid;

   always_comb begin
      w_stage_n = r_stage;
      w_seen_n  = r_seen;
      w_err_n   = r_err;
      w_dps_n   = r_dps;
      if (w_cap) begin
         w_stage_n[w_pos] = w_dec[3:0];
         w_seen_n[w_pos]  = 1'b1;
         w_err_n[w_pos]   = w_dec[4];
         w_dps_n[w_pos]   = ~r_in[11];
      end
   end

   assign w_done    = (w_seen_n == 4'hF);
   assign w_timeout = (r_state == S_COLLECT) && (r_tmo == c_TMO_PEN);
   assign w_value   = 14'(w_stage_n[3]) * 14'd1000 + 14'(w_stage_n[2]) * 14'd100
                    + 14'(w_stage_n[1]) * 14'd10   + 14'(w_stage_n[0]);

   // Completion is resolved in the capture cycle so results appear one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_stage     <= '0;
         r_seen      <= '0;
         r_err       <= '0;
         r_dps       <= '0;
         r_tmo       <= '0;
         digit_1     <= '0;
         digit_2     <= '0;
         digit_3     <= '0;
         digit_4     <= '0;
         value       <= '0;
         dp          <= '0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         scan_lost   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         scan_lost   <= 1'b0;
         r_stage     <= w_stage_n;
         r_dps       <= w_dps_n;
         if (w_done) begin
            if (|w_err_n) begin
               frame_error <= 1'b1;
            end else begin
               digit_1     <= w_stage_n[3];
               digit_2     <= w_stage_n[2];
               digit_3     <= w_stage_n[1];
               digit_4     <= w_stage_n[0];
               value       <= w_value;
               dp          <= w_dps_n;
               frame_valid <= 1'b1;
            end
            r_seen  <= '0;
            r_err   <= '0;
            r_tmo   <= '0;
            r_state <= S_IDLE;
         end else if (w_timeout) begin
            scan_lost <= 1'b1;
            r_seen    <= '0;
            r_err     <= '0;
            r_tmo     <= '0;
            r_state   <= S_IDLE;
         end else begin
            r_seen <= w_seen_n;
            r_err  <= w_err_n;
            if (r_state == S_IDLE) begin
               if (w_cap) begin
                  r_state <= S_COLLECT;
                  r_tmo   <= '0;
               end
            end else begin
               r_tmo <= r_tmo + 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seven_segment_capture                                     |
// | Description : Self-checking bench: directed scans plus random scans        |
// |               against a frame-level reference model.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seven_segment_capture;

   localparam int SETTLE = 4;
   localparam int TMO    = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic [3:0]  digit_1, digit_2, digit_3, digit_4;
   logic [13:0] value;
   logic [3:0]  dp;
   logic        frame_valid, frame_error, scan_lost;

   seven_segment_capture #(
      .SETTLE_CYCLES (SETTLE),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .seg        (seg),
      .an         (an),
      .digit_1    (digit_1),
      .digit_2    (digit_2),
      .digit_3    (digit_3),
      .digit_4    (digit_4),
      .value      (value),
      .dp         (dp),
      .frame_valid(frame_valid),
      .frame_error(frame_error),
      .scan_lost  (scan_lost)
   );

   always #5 clk = ~clk;

   logic [6:0]  tbl [10];
   logic [11:0] m_prev;
   int          m_run;
   logic [3:0]  m_seen, m_err, m_dpb;
   int          m_stage [4];
   bit          m_collect;
   int          m_first;
   int          e_digit [4];
   int          e_value;
   logic [3:0]  e_dp;
   bit          e_fv, e_fe, e_sl;
   int          cyc = 0;
   int          checks = 0, errors = 0;
   bit          cmp_en = 1'b0;
   int          fv_cnt = 0, fe_cnt = 0, sl_cnt = 0, fv_cyc = 0, sl_cyc = 0;
   int          last_start;

   initial begin
      tbl[0] = 7'h40; tbl[1] = 7'h79; tbl[2] = 7'h24; tbl[3] = 7'h30; tbl[4] = 7'h19;
      tbl[5] = 7'h12; tbl[6] = 7'h02; tbl[7] = 7'h78; tbl[8] = 7'h00; tbl[9] = 7'h10;
   end

   // Reference: a dwell is captured when it has been sampled SETTLE+1 times in a row.
   always @(posedge clk) begin : model
      logic [11:0] x;
      int pos, nlow, d;
      bit cap;
      cyc++;
      if (rst) begin
         m_prev = 12'hFFF; m_run = 0; m_seen = 0; m_err = 0; m_dpb = 0; m_collect = 0;
         for (int i = 0; i < 4; i++) begin m_stage[i] = 0; e_digit[i] = 0; end
         e_value = 0; e_dp = 0; e_fv = 0; e_fe = 0; e_sl = 0;
      end else begin
`ifdef SEG_CAPTURE_DP_EN
         x = {seg[7], seg[6:0], an};
`else
         x = {1'b1, seg[6:0], an};
`endif
         m_run  = (x == m_prev) ? m_run + 1 : 0;
         m_prev = x;
         e_fv = 0; e_fe = 0; e_sl = 0;
         nlow = 0; pos = 0;
         for (int i = 0; i < 4; i++) if (!an[i]) begin nlow++; pos = i; end
         cap = (m_run == SETTLE) && (nlow == 1);
         if (cap) begin
            d = -1;
            for (int k = 0; k < 10; k++) if (tbl[k] == seg[6:0]) d = k;
            m_stage[pos] = (d < 0) ? 0 : d;
            m_err[pos]   = (d < 0);
`ifdef SEG_CAPTURE_DP_EN
            m_dpb[pos] = ~seg[7];
`else
            m_dpb[pos] = 1'b0;
`endif
            m_seen[pos] = 1'b1;
         end
         if (m_seen == 4'hF) begin
            if (m_err != 0) e_fe = 1;
            else begin
               e_fv = 1;
               for (int i = 0; i < 4; i++) e_digit[i] = m_stage[i];
               e_value = m_stage[3] * 1000 + m_stage[2] * 100 + m_stage[1] * 10 + m_stage[0];
               e_dp = m_dpb;
            end
            m_seen = 0; m_err = 0; m_collect = 0;
         end else if (m_collect && (cyc - m_first == TMO - 1)) begin
            e_sl = 1; m_seen = 0; m_err = 0; m_collect = 0;
         end else if (cap && !m_collect) begin
            m_collect = 1; m_first = cyc;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("digit_1", digit_1, e_digit[3]);
         chk("digit_2", digit_2, e_digit[2]);
         chk("digit_3", digit_3, e_digit[1]);
         chk("digit_4", digit_4, e_digit[0]);
         chk("value", value, e_value);
         chk("dp", dp, e_dp);
         chk("frame_valid", frame_valid, e_fv);
         chk("frame_error", frame_error, e_fe);
         chk("scan_lost", scan_lost, e_sl);
         if (frame_valid === 1'b1) begin fv_cnt++; fv_cyc = cyc; end
         if (frame_error === 1'b1) fe_cnt++;
         if (scan_lost === 1'b1) begin sl_cnt++; sl_cyc = cyc; end
      end
   end

   task automatic put(input logic [7:0] s, input logic [3:0] a, input int n);
      seg = s; an = a;
      repeat (n) @(negedge clk);
   endtask

   task automatic scan(input logic [7:0] s3, s2, s1, s0, input int dw);
      put(s3, 4'b0111, dw);
      put(s2, 4'b1011, dw);
      put(s1, 4'b1101, dw);
      last_start = cyc;
      put(s0, 4'b1110, dw);
   endtask

   initial begin : stim
      int fv0, fe0, sl0, st;
      logic [3:0] a;
      logic [7:0] s;
      int p;
      bit ordered;
      rst = 1'b1; seg = 8'hFF; an = 4'hF;
      @(negedge clk);
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_value", value, 0);
      chk("reset_valid", frame_valid, 0);
      rst = 1'b0;
      put(8'hFF, 4'hF, 5);

      // clean scan 0,0,3,7
      fv0 = fv_cnt;
      scan(8'hC0, 8'hC0, 8'hB0, 8'hF8, 10);
      put(8'hFF, 4'hF, 10);
      chk("clean_pulses", fv_cnt - fv0, 1);
      chk("clean_latency", fv_cyc - last_start, 5);
      chk("clean_digits", {digit_1, digit_2, digit_3, digit_4}, 16'h0037);
      chk("clean_value", value, 37);

      // undecodable position
      fv0 = fv_cnt; fe0 = fe_cnt;
      scan(8'h90, 8'hFF, 8'hF9, 8'hA4, 10);
      put(8'hFF, 4'hF, 10);
      chk("undec_error", fe_cnt - fe0, 1);
      chk("undec_novalid", fv_cnt - fv0, 0);
      chk("undec_value", value, 37);

      // partial scan times out, next full scan is good
      sl0 = sl_cnt; st = cyc;
      put(8'h80, 4'b0111, 10);
      put(8'hF9, 4'b1011, 10);
      put(8'hA4, 4'b1101, 10);
      put(8'hFF, 4'hF, 60);
      chk("partial_lost", sl_cnt - sl0, 1);
      chk("partial_latency", sl_cyc - st, 68);
      chk("partial_value", value, 37);
      fv0 = fv_cnt;
      scan(8'hF9, 8'hA4, 8'hB0, 8'h99, 10);
      put(8'hFF, 4'hF, 10);
      chk("after_lost_valid", fv_cnt - fv0, 1);
      chk("after_lost_value", value, 1234);

      // glitchy dwell on the last position
      fv0 = fv_cnt;
      put(8'hF9, 4'b0111, 10);
      put(8'hA4, 4'b1011, 10);
      put(8'h99, 4'b1101, 10);
      for (int i = 0; i < 2; i++) begin
         put(8'h92, 4'b1110, 2);
         put(8'hF9, 4'b1110, 2);
      end
      last_start = cyc;
      put(8'h92, 4'b1110, 12);
      put(8'hFF, 4'hF, 10);
      chk("glitch_pulses", fv_cnt - fv0, 1);
      chk("glitch_latency", fv_cyc - last_start, 5);
      chk("glitch_digit4", digit_4, 5);
      chk("glitch_value", value, 1245);

      // decimal point on an[2]
      scan(8'hF9, 8'h24, 8'hB0, 8'h99, 10);
      put(8'hFF, 4'hF, 10);
`ifdef SEG_CAPTURE_DP_EN
      chk("dp_capture", dp, 4'b0100);
`else
      chk("dp_capture", dp, 4'b0000);
`endif

      // reset mid-frame
      fv0 = fv_cnt; fe0 = fe_cnt; sl0 = sl_cnt;
      put(8'h80, 4'b0111, 10);
      put(8'h82, 4'b1011, 10);
      rst = 1'b1;
      put(8'hFF, 4'hF, 3);
      rst = 1'b0;
      chk("rst_value", value, 0);
      chk("rst_dp", dp, 0);
      put(8'hB0, 4'b1101, 10);
      put(8'h90, 4'b1110, 10);
      put(8'hFF, 4'hF, 5);
      chk("rst_no_pulse", (fv_cnt - fv0) + (fe_cnt - fe0) + (sl_cnt - sl0), 0);
      put(8'hA4, 4'b0111, 10);
      last_start = cyc;
      put(8'h99, 4'b1011, 10);
      put(8'hFF, 4'hF, 5);
      chk("rst_refill_valid", fv_cnt - fv0, 1);
      chk("rst_refill_latency", fv_cyc - last_start, 5);
      chk("rst_refill_value", value, 2439);

      // randomized scans
      for (int f = 0; f < 40; f++) begin
         ordered = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0) begin
            rst = 1'b1;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            rst = 1'b0;
         end
         for (int j = 0; j < 4; j++) begin
            p = ordered ? 3 - j : int'($urandom_range(0, 3));
            a = 4'hF;
            a[p] = 1'b0;
            if ($urandom_range(0, 9) == 0) a = 4'($urandom);
            s = {1'($urandom), tbl[$urandom_range(0, 9)]};
            if ($urandom_range(0, 11) == 0) s = 8'($urandom);
            if ($urandom_range(0, 5) == 0) put(8'($urandom), a, $urandom_range(1, 3));
            put(s, a, $urandom_range(1, 12));
         end
         if ($urandom_range(0, 7) == 0) put(8'hFF, 4'hF, $urandom_range(40, 80));
         else put(8'hFF, 4'hF, $urandom_range(0, 4));
      end
      put(8'hFF, 4'hF, 80);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not end, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/seven_segment_capture.md
# seven_segment_capture

- Receiving end of the `seven_display` multiplexed seven-segment link.
- Samples the board-level `seg`/`an` signals, waits for each anode dwell to settle, and decodes the active-low segment pattern back to a BCD digit.
- Reassembles the four digits into a frame and presents them as digits plus a binary value.
- Used as an on-board loopback checker for the countdown/score display and as a scoreboard source in system benches.

## Interface
- `SETTLE_CYCLES`, 4: consecutive identical input cycles required before a dwell is sampled (range 1..255).
- `TIMEOUT_CYCLES`, 1000000: maximum cycles from the first capture of a frame to frame completion.
- `clk` in 1: system clock. One clock.
- `rst` in 1: reset. Synchronous, active-high.
- `seg` in 8: active-low segments; `seg[6:0]` = g,f,e,d,c,b,a and `seg[7]` = dp.
- `an` in 4: active-low anodes. `an[0]` is the rightmost position (`digit_4`) and `an[3]` is the leftmost (`digit_1`).
- `digit_1`..`digit_4` out 4 each: last good frame, BCD. `digit_4` is the least significant.
- `value` out 14: `digit_1*1000 + digit_2*100 + digit_3*10 + digit_4`, registered.
- `dp` out 4: captured decimal points, active-high, indexed like `an`.
- `frame_valid` out 1: one-cycle pulse when the outputs update.
- `frame_error` out 1: one-cycle pulse when a frame completes with an undecodable position.
- `scan_lost` out 1: one-cycle pulse when a frame times out.

## Operation
- **Input register:** `{seg, an}` is registered once into `in_q`.
- **Stability counter:**
  - Increments, saturating at `SETTLE_CYCLES`, while `in_q` equals its previous value.
  - Resets to 0 on any change.
- **Valid dwell:** exactly one bit of `in_q.an` is low. Zero or more than one low bit is never sampled, but it does not clear the frame.
- **Capture:**
  - Happens once per dwell, on the cycle the counter reaches `SETTLE_CYCLES`.
  - The position's staging nibble, dp bit and error bit are written, and its bit in the 4-bit `seen` mask is set.
  - The dwell is not re-sampled until `in_q` changes.
- **Decode table** (active-low `seg[6:0]`, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Any other pattern, including blank 7F, sets the position's error bit. The staging nibble is written as 0.
- **Recapture:** capturing an already-seen position in the same frame overwrites it (latest wins).
- **Frame states:** IDLE (`seen`=0) -> COLLECT (first capture, timeout counter starts from 0) -> COMPLETE (`seen`=1111).
- **COMPLETE, no error bit set:**
  - `digit_1`..`digit_4`, `dp` and `value` update.
  - `frame_valid` pulses.
- **COMPLETE, any error bit set:** `frame_error` pulses and all data outputs hold.
- **After COMPLETE:** `seen`, the error bits and the timeout counter clear, and the state returns to IDLE.
- **Timeout:** if the timeout counter reaches `TIMEOUT_CYCLES - 1` in COLLECT, `scan_lost` pulses, everything clears to IDLE and data outputs hold.
  - If completion and timeout coincide, completion wins.
- **Value width:** `value` is at most 9999, which fits 14 bits. It is computed from the staging nibbles and registered with the digits.
- **Reset mid-frame:** staging data and `seen` are discarded and no pulse is generated.

## Timing
- **Reset values:** all digits 0, `value` 0, `dp` 0, `frame_valid` 0, `frame_error` 0, `scan_lost` 0.
- **Capture timing:** with inputs stable from cycle t, capture takes effect at the end of cycle t+`SETTLE_CYCLES`. This is 1 cycle for the input register plus `SETTLE_CYCLES` of counting.
- **Frame result timing:** outputs and `frame_valid` (or `frame_error`) are asserted in the cycle after the capture that completes the frame.
- **Pulse exclusivity:** at most one of `frame_valid`, `frame_error`, `scan_lost` is high in any cycle.
- **Output stability:** data outputs change only in a `frame_valid` cycle or on reset.

## Configuration
- **Macro:** `SEG_CAPTURE_DP_EN`.
- **Defined:**
  - `seg[7]` is captured per position and published on `dp` with the frame.
  - `seg[7]` also takes part in the stability compare.
- **Undefined:**
  - `seg[7]` is ignored entirely, including in the stability compare.
  - `dp` is tied to 4'b0000.
  - Decode uses `seg[6:0]` only.

## Test plan
All scenarios use `SETTLE_CYCLES`=4 and `TIMEOUT_CYCLES`=64.

1. **Clean scan:** a scan driving 0,0,3,7 (`an` 0111,1011,1101,1110 with seg 40,40,30,78), 10-cycle dwells -> `digit_1`..`digit_4`=0,0,3,7, `value`=37, single `frame_valid` 1 cycle after the fourth capture.
2. **Glitchy dwell:** `seg` toggles every 2 cycles for 8 cycles, then holds 12 -> exactly one capture of digit 5 (seg 12), 5 cycles after it settles.
3. **Undecodable position:** a frame with one position showing 7F -> `frame_error` pulse, `value` stays 37, no `frame_valid`.
4. **Partial scan:** only three anodes driven -> `scan_lost` 64 cycles after the first capture, outputs unchanged. The next full scan gives a good `frame_valid`.
5. **Reset mid-frame:** `rst` after two captures -> no pulse, outputs 0. The next frame needs all four positions again.
6. **Decimal point:** with `SEG_CAPTURE_DP_EN` defined, `seg[7]`=0 on `an[2]` -> `dp`=4'b0100. Undefined -> `dp`=0.
